ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 138 +++++++++++++
 tb/tb_ex_operand_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - EX operand stage: forwarding, ALU control decode and single-entry skid register
module ex_operand_stage #(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_WIDTH-1:0] rs1_data,
    input  logic [REG_WIDTH-1:0] rs2_data,
    input  logic [REG_WIDTH-1:0] imm,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rd,
    input  logic [1:0]           alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_30,
    input  logic                 alu_src,
    input  logic                 reg_write,
    input  logic                 exmem_reg_write,
    input  logic [4:0]           exmem_rd,
    input  logic [REG_WIDTH-1:0] exmem_result,
    input  logic                 memwb_reg_write,
    input  logic [4:0]           memwb_rd,
    input  logic [REG_WIDTH-1:0] memwb_result,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [REG_WIDTH-1:0] in1,
    output logic [REG_WIDTH-1:0] in2,
    output logic [3:0]           alu_control,
    output logic [REG_WIDTH-1:0] store_data,
    output logic [4:0]           ex_rd,
    output logic                 ex_reg_write
);

    logic                 valid_q, valid_d;
    logic                 reg_write_q, reg_write_d;
    logic [REG_WIDTH-1:0] in1_q, in1_d;
    logic [REG_WIDTH-1:0] in2_q, in2_d;
    logic [REG_WIDTH-1:0] store_q, store_d;
    logic [3:0]           ctl_q, ctl_d;
    logic [4:0]           rd_q, rd_d;

    logic                 accept;
    logic [REG_WIDTH-1:0] fwd_rs1, fwd_rs2;
    logic [3:0]           ctl_dec;

    assign id_ready = ~valid_q | ex_ready;
    assign accept   = id_valid & id_ready;

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
    always_comb begin
        fwd_rs1 = rs1_data;
        if (rs1 != 5'd0 && exmem_reg_write && exmem_rd == rs1) begin
            fwd_rs1 = exmem_result;
        end else if (rs1 != 5'd0 && memwb_reg_write && memwb_rd == rs1) begin
            fwd_rs1 = memwb_result;
        end
        fwd_rs2 = rs2_data;
        if (rs2 != 5'd0 && exmem_reg_write && exmem_rd == rs2) begin
            fwd_rs2 = exmem_result;
        end else if (rs2 != 5'd0 && memwb_reg_write && memwb_rd == rs2) begin
            fwd_rs2 = memwb_result;
        end
    end

    always_comb begin
        ctl_dec = 4'b1111;
        case (alu_op)
            2'b00: ctl_dec = 4'b0010;
            2'b01: ctl_dec = 4'b0110;
            2'b10: begin
                case (funct3)
                    3'b000:  ctl_dec = funct7_30 ? 4'b0110 : 4'b0010;
                    3'b111:  ctl_dec = 4'b0000;
                    3'b110:  ctl_dec = 4'b0001;
                    default: ctl_dec = 4'b1111;
                endcase
            end
            default: ctl_dec = 4'b1111;
        endcase
    end

    // Flush beats accept: a dropped instruction leaves the data fields untouched
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        store_d     = store_q;
        ctl_d       = ctl_q;
        rd_d        = rd_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            reg_write_d = reg_write;
            in1_d       = fwd_rs1;
            in2_d       = alu_src ? imm : fwd_rs2;
            store_d     = fwd_rs2;
            ctl_d       = ctl_dec;
            rd_d        = rd;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            store_q     <= '0;
            ctl_q       <= 4'b0000;
            rd_q        <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            store_q     <= store_d;
            ctl_q       <= ctl_d;
            rd_q        <= rd_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign in1          = in1_q;
    assign in2          = in2_q;
    assign store_data   = store_q;
    assign alu_control  = ctl_q;
    assign ex_rd        = rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed and randomized checks of ex_operand_stage against a reference model
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_ready;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_30, alu_src, reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        flush, ex_ready, ex_valid, ex_reg_write;
    logic [63:0] in1, in2, store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    // reference state
    logic        m_valid, m_rw, m_rw_zero;
    logic [63:0] m_in1, m_in2, m_sd;
    logic [3:0]  m_ctl;
    logic [4:0]  m_rd;

    logic [63:0] a_in1, a_in2, a_sd;
    logic [3:0]  a_ctl;

    ex_operand_stage #(.REG_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_op(alu_op), .funct3(funct3), .funct7_30(funct7_30),
        .alu_src(alu_src), .reg_write(reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .in1(in1), .in2(in2), .alu_control(alu_control), .store_data(store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] raw);
        if (idx == 5'd0) return raw;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return raw;
    endfunction

    function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
        if (op == 2'd0) return 4'b0010;
        if (op == 2'd1) return 4'b0110;
        if (op == 2'd3) return 4'b1111;
        if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
        if (f3 == 3'd7) return 4'b0000;
        if (f3 == 3'd6) return 4'b0001;
        return 4'b1111;
    endfunction

    task automatic model_edge();
        logic acc;
        acc = id_valid && (!m_valid || ex_ready);
        if (reset) begin
            m_valid = 0; m_rw = 0; m_rw_zero = 1;
            m_in1 = 0; m_in2 = 0; m_sd = 0; m_ctl = 0; m_rd = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_rw_zero = 1;
        end else if (acc) begin
            m_valid = 1; m_rw = reg_write; m_rw_zero = 0;
            m_in1 = ref_fwd(rs1, rs1_data);
            m_sd  = ref_fwd(rs2, rs2_data);
            m_in2 = alu_src ? imm : m_sd;
            m_ctl = ref_ctl(alu_op, funct3, funct7_30);
            m_rd  = rd;
        end else if (ex_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ex_valid"}, {63'd0, ex_valid}, {63'd0, m_valid});
        if (m_valid || m_rw_zero) chk({tag, ".ex_reg_write"}, {63'd0, ex_reg_write}, {63'd0, m_rw});
        if (m_valid) begin
            chk({tag, ".in1"}, in1, m_in1);
            chk({tag, ".in2"}, in2, m_in2);
            chk({tag, ".store_data"}, store_data, m_sd);
            chk({tag, ".alu_control"}, {60'd0, alu_control}, {60'd0, m_ctl});
            chk({tag, ".ex_rd"}, {59'd0, ex_rd}, {59'd0, m_rd});
        end
    endtask

    // inputs are settled here; check id_ready, take one edge, update model, check outputs
    task automatic tick(input string tag);
        #1;
        chk({tag, ".id_ready"}, {63'd0, id_ready}, {63'd0, (!m_valid || ex_ready)});
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                             input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] im,
                             input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic src, input logic rw);
        rs1 = r1; rs2 = r2; rd = d; rs1_data = d1; rs2_data = d2; imm = im;
        alu_op = op; funct3 = f3; funct7_30 = f7; alu_src = src; reg_write = rw;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        reset = 1; id_valid = 0; flush = 0; ex_ready = 1;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        no_fwd();
        m_valid = 0; m_rw = 0; m_rw_zero = 0;
        m_in1 = 0; m_in2 = 0; m_sd = 0; m_ctl = 0; m_rd = 0;

        // reset state, with an offered instruction that reset must override
        id_valid = 1;
        set_instr(1, 2, 3, 64'h11, 64'h22, 64'h33, 2'b00, 0, 0, 0, 1);
        @(posedge clk); model_edge();
        tick("reset");
        chk("reset.in1", in1, 0);
        chk("reset.alu_control", {60'd0, alu_control}, 0);
        chk("reset.ex_reg_write", {63'd0, ex_reg_write}, 0);
        reset = 0; id_valid = 0;
        #1 chk("post_reset.id_ready", {63'd0, id_ready}, 1);
        tick("idle");

        // basic accept: sub decode
        id_valid = 1; ex_ready = 1;
        set_instr(1, 2, 4, 64'd5, 64'd3, 64'h99, 2'b10, 3'b000, 1, 0, 1);
        tick("accept");
        chk("accept.ex_valid", {63'd0, ex_valid}, 1);
        chk("accept.in1", in1, 64'd5);
        chk("accept.in2", in2, 64'd3);
        chk("accept.alu_control", {60'd0, alu_control}, 4'b0110);

        // forwarding priority
        set_instr(7, 0, 5, 64'h1, 64'h2, 64'h3, 2'b00, 0, 0, 1, 1);
        exmem_reg_write = 1; exmem_rd = 7; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 64'hBB;
        tick("fwd_exmem");
        chk("fwd_exmem.in1", in1, 64'hAA);
        chk("fwd_exmem.in2_imm", in2, 64'h3);
        exmem_reg_write = 0;
        tick("fwd_memwb");
        chk("fwd_memwb.in1", in1, 64'hBB);

        // x0 never forwarded
        set_instr(0, 0, 6, 64'h0, 64'h0, 64'h0, 2'b01, 0, 0, 0, 1);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 64'h55; memwb_reg_write = 0;
        tick("x0");
        chk("x0.in1", in1, 64'h0);
        chk("x0.store_data", store_data, 64'h0);
        no_fwd();

        // stall three cycles with a new instruction waiting
        set_instr(3, 4, 9, 64'hA1, 64'hB2, 64'hC3, 2'b10, 3'b111, 0, 0, 1);
        tick("stall_load");
        a_in1 = in1; a_in2 = in2; a_sd = store_data; a_ctl = alu_control;
        chk("stall_load.alu_control", {60'd0, alu_control}, 4'b0000);
        ex_ready = 0;
        set_instr(8, 9, 10, 64'hD4, 64'hE5, 64'hF6, 2'b10, 3'b110, 0, 1, 1);
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.id_ready", {63'd0, id_ready}, 0);
            tick("stall");
            chk("stall.in1", in1, a_in1);
            chk("stall.in2", in2, a_in2);
            chk("stall.store_data", store_data, a_sd);
            chk("stall.alu_control", {60'd0, alu_control}, {60'd0, a_ctl});
        end
        ex_ready = 1;
        tick("stall_release");
        chk("stall_release.in1", in1, 64'hD4);
        chk("stall_release.in2", in2, 64'hF6);
        chk("stall_release.alu_control", {60'd0, alu_control}, 4'b0001);
        no_fwd();

        // flush overrides a simultaneous accept
        flush = 1; id_valid = 1;
        tick("flush");
        chk("flush.ex_valid", {63'd0, ex_valid}, 0);
        chk("flush.ex_reg_write", {63'd0, ex_reg_write}, 0);
        flush = 0;

        // reset while stalled
        tick("pre_stall");
        ex_ready = 0; id_valid = 0;
        tick("held");
        reset = 1;
        tick("reset_stall");
        chk("reset_stall.ex_valid", {63'd0, ex_valid}, 0);
        chk("reset_stall.in2", in2, 0);
        chk("reset_stall.store_data", store_data, 0);
        chk("reset_stall.ex_rd", {59'd0, ex_rd}, 0);
        reset = 0;
        #1 chk("reset_stall.id_ready", {63'd0, id_ready}, 1);

        // randomized traffic; small index space makes forwarding hits frequent
        for (int n = 0; n < 400; n++) begin
            id_valid  = ($urandom_range(0, 3) != 0);
            ex_ready  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result    = {$urandom, $urandom};
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result    = {$urandom, $urandom};
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
